// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width; a 1-bit counter is the floor so WIDTH=2 still works.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bout is the borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Pure combinational difference and borrow.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B, one bit per clock, LSB first.
//
// Handshake: start is accepted on a rising edge where ready=1 (IDLE or DONE);
// a and b are sampled only on that edge. done pulses for one cycle with the
// result outputs updated in that same cycle; results then hold until the next
// completion. start while busy is ignored.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             ovf,
  output logic             zero,
  output state_t           state_dbg
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] acc;      // upper WIDTH-1 result bits collected so far
  logic             bq;       // borrow carried between bit slices
  logic [CW-1:0]    cnt;
  logic             cell_d, cell_bout;
  logic             accept, last_bit;
  logic [WIDTH-1:0] acc_next;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bq),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign accept    = ready && start;
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign acc_next  = {cell_d, acc};
  assign state_dbg = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) state_d = ST_DONE;
      end
      ST_DONE: begin
        ready   = 1'b1;
        done    = 1'b1;
        state_d = start ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand shifters, accumulator, borrow FF and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      bq   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      bq   <= 1'b0;
      cnt  <= '0;
    end else if (state_q == ST_RUN) begin
      acc  <= acc_next[WIDTH-1:1];
      bq   <= cell_bout;
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CW'(1);
    end
  end

  // Result registers load only on the edge that finishes the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d      <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (state_q == ST_RUN && last_bit) begin
      d      <= acc_next;
      borrow <= cell_bout;
      ovf    <= (a_sh[0] != b_sh[0]) && (cell_d != a_sh[0]);
      zero   <= (acc_next == '0);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a scoreboard and a done monitor.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 8;
  localparam int RW = W + 3;   // {d, borrow, ovf, zero}

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         ready, busy, done, borrow, ovf, zero;
  logic [W-1:0] d;
  state_t       state_dbg;

  logic fa, fb, fbin, fd, fbout;

  logic [RW-1:0] exp_q[$];
  int            lat_q[$];
  int            cyc = 0;
  int            chk_cnt = 0;
  int            pass_cnt = 0;
  logic [W-1:0]  last_d = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .d(d),
    .borrow(borrow), .ovf(ovf), .zero(zero), .state_dbg(state_dbg)
  );

  full_subtractor u_fs (.a(fa), .b(fb), .bin(fbin), .d(fd), .bout(fbout));

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    chk_cnt++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // monitor: pops the scoreboard whenever done is presented
  task automatic monitor_loop();
    logic [RW-1:0] e;
    int lat;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_done: got done=1 expected no pulse");
        end else begin
          e = exp_q.pop_front();
          lat = (lat_q.size() != 0) ? lat_q.pop_front() : -1;
          chk("d", 32'(d), 32'(e[RW-1:3]));
          chk("borrow", 32'(borrow), 32'(e[2]));
          chk("ovf", 32'(ovf), 32'(e[1]));
          chk("zero", 32'(zero), 32'(e[0]));
          chk("ready_in_done", 32'(ready), 32'd1);
          chk("latency", 32'(cyc), 32'(lat));
        end
      end
    end
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("ready_timeout");
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail_now("drain_timeout");
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  // driver: issue one op; optionally poke start while busy at RUN cycle 3
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [RW-1:0] exp, input bit inject);
    wait_ready();
    a = av; b = bv; start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat_q.push_back(cyc + W);
    chk("busy_run", 32'(busy), 32'd1);
    chk("ready_run", 32'(ready), 32'd0);
    chk("d_hold", 32'(d), 32'(last_d));
    if (inject) begin
      @(negedge clk);
      a = 8'hFF; b = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_ignored_start", 32'(busy), 32'd1);
    end
    last_d = exp[RW-1:3];
  endtask

  initial begin
    logic [7:0] dv;
    logic [7:0] bv;
    logic [2:0] idx;
    bit ok;
    dv = 8'b1001_0110;
    bv = 8'b1000_1110;

    fork
      monitor_loop();
    join_none

    // full-subtractor truth table
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      {fa, fb, fbin} = idx;
      #1;
      chk("fs_d", 32'(fd), 32'(dv[i]));
      chk("fs_bout", 32'(fbout), 32'(bv[i]));
    end

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_outs", 32'({d, borrow, ovf, zero}), 32'd0);
    rst_n = 1'b1;

    // {d, borrow, ovf, zero}
    do_op(8'h05, 8'h03, {8'h02, 3'b000}, 1'b0); drain();
    do_op(8'h03, 8'h05, {8'hFE, 3'b100}, 1'b0); drain();
    do_op(8'h80, 8'h01, {8'h7F, 3'b010}, 1'b0); drain();
    do_op(8'h7F, 8'hFF, {8'h80, 3'b110}, 1'b0); drain();
    do_op(8'h5A, 8'h5A, {8'h00, 3'b001}, 1'b0); drain();

    // ignored start, then back-to-back start held in the DONE cycle
    do_op(8'h10, 8'h01, {8'h0F, 3'b000}, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("done_timeout");
    a = 8'h20; b = 8'h10; start = 1'b1;
    exp_q.push_back({8'h10, 3'b000});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat_q.push_back(cyc + W);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_d_hold", 32'(d), 32'h0F);
    last_d = 8'h10;
    drain();

    // reset in the middle of RUN: no scoreboard entry, so any done is flagged
    wait_ready();
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_outs", 32'({d, borrow, ovf, zero}), 32'd0);
    chk("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_d", 32'(d), 32'd0);
    last_d = '0;

    do_op(8'hC8, 8'h64, {8'h64, 3'b010}, 1'b0); drain();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
